dram_kernel_loader: RTL and testbench

Streams kernel weights from external DRAM into one of the on-chip kernel memories. It issues sequential 512-bit DRAM read requests and unpacks each returned word through a bit-level gearbox into 75-bit kernel rows. It then writes those rows into the selected kernel BRAM starting at row 0. It is the writer side of the kernel-memory port that the convolution units read, and it sits between the DRAM read interface and the kernel BRAMs.

---
 rtl/dram_kernel_loader.sv | 135 +++++++++++++
 tb/tb_dram_kernel_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_kernel_loader.sv
// Kernel weight loader: fetches sequential DRAM words and unpacks them through a
// bit gearbox into contiguous kernel rows written to one kernel BRAM from row 0.
module dram_kernel_loader #(
    parameter int DRAM_DATA_BITS = 512,
    parameter int DRAM_ADDR_BITS = 29,
    parameter int KER_NUM        = 3,
    parameter int KER_WIDTH      = 75,
    parameter int KER_HEIGHT_MAX = 1920
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [DRAM_ADDR_BITS-1:0]           dram_base,
    input  logic [$clog2(KER_NUM)-1:0]          ker_sel,
    input  logic [$clog2(KER_HEIGHT_MAX+1)-1:0] ker_rows,
    output logic                                busy,
    output logic                                done,
    output logic                                dram_rd_req,
    output logic [DRAM_ADDR_BITS-1:0]           dram_rd_addr,
    input  logic                                dram_rd_ack,
    input  logic                                dram_rd_valid,
    input  logic [DRAM_DATA_BITS-1:0]           dram_rd_data,
    output logic [KER_NUM-1:0]                  ker_wr_en,
    output logic [$clog2(KER_HEIGHT_MAX)-1:0]   ker_wr_addr,
    output logic [KER_WIDTH-1:0]                ker_wr_data
);
    localparam int BUF_W   = DRAM_DATA_BITS + KER_WIDTH - 1;
    localparam int CNT_W   = $clog2(BUF_W + 1);
    localparam int SEL_W   = $clog2(KER_NUM);
    localparam int ROWS_W  = $clog2(KER_HEIGHT_MAX + 1);
    localparam int WADDR_W = $clog2(KER_HEIGHT_MAX);
    localparam logic [CNT_W-1:0] ROW_BITS  = CNT_W'(KER_WIDTH);
    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DRAM_DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [BUF_W-1:0]          gbx_q, gbx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ROWS_W-1:0]         rows_q, rows_d;
    logic [WADDR_W-1:0]        waddr_q, waddr_d;
    logic [DRAM_ADDR_BITS-1:0] raddr_q, raddr_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [CNT_W-1:0]          cnt_rem;
    logic                      emit;

    assign cnt_rem = cnt_q - ROW_BITS;
    assign emit    = (state_q == S_DRAIN) && (cnt_q >= ROW_BITS) && (rows_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gbx_q   <= '0;
            cnt_q   <= '0;
            rows_q  <= '0;
            waddr_q <= '0;
            raddr_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            gbx_q   <= gbx_d;
            cnt_q   <= cnt_d;
            rows_q  <= rows_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gbx_d   = gbx_q;
        cnt_d   = cnt_q;
        rows_d  = rows_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    raddr_d = dram_base;
                    sel_d   = ker_sel;
                    rows_d  = ker_rows;
                    waddr_d = '0;
                    gbx_d   = '0;
                    cnt_d   = '0;
                    state_d = (ker_rows == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (dram_rd_ack) begin
                    raddr_d = raddr_q + DRAM_ADDR_BITS'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only requested while fewer than one row is buffered, so the word always fits.
                if (dram_rd_valid) begin
                    gbx_d   = gbx_q | (BUF_W'(dram_rd_data) << cnt_q);
                    cnt_d   = cnt_q + WORD_BITS;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (emit) begin
                    gbx_d   = gbx_q >> KER_WIDTH;
                    cnt_d   = cnt_rem;
                    rows_d  = rows_q - ROWS_W'(1);
                    waddr_d = waddr_q + WADDR_W'(1);
                    if (rows_q == ROWS_W'(1)) begin
                        state_d = S_DONE;
                    end else if (cnt_rem < ROW_BITS) begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = (rows_q != '0) ? S_REQ : S_DONE;
                end
            end
            S_DONE: begin
                gbx_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign dram_rd_req  = (state_q == S_REQ);
    assign dram_rd_addr = raddr_q;
    assign ker_wr_en    = emit ? (KER_NUM'(1) << sel_q) : '0;
    assign ker_wr_addr  = waddr_q;
    assign ker_wr_data  = gbx_q[KER_WIDTH-1:0];
endmodule

// File: tb/tb_dram_kernel_loader.sv
// Directed bench for dram_kernel_loader: DRAM responder model, write scoreboard
// built from a bit-level model of the packed row stream.
`timescale 1ns/1ps
module tb_dram_kernel_loader;
    localparam int DB = 512, AB = 29, KN = 3, KW = 75, KH = 1920;
    localparam int SW = $clog2(KN), RW = $clog2(KH + 1), WW = $clog2(KH);

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AB-1:0] dram_base = '0;
    logic [SW-1:0] ker_sel = '0;
    logic [RW-1:0] ker_rows = '0;
    logic          busy, done, dram_rd_req;
    logic [AB-1:0] dram_rd_addr;
    logic          dram_rd_ack = 1'b0;
    logic          dram_rd_valid;
    logic [DB-1:0] dram_rd_data;
    logic [KN-1:0] ker_wr_en;
    logic [WW-1:0] ker_wr_addr;
    logic [KW-1:0] ker_wr_data;

    logic          rv = 1'b0, sv = 1'b0;
    logic [DB-1:0] rdata = '0, sdata = '0;
    assign dram_rd_valid = rv | sv;
    assign dram_rd_data  = sv ? sdata : rdata;

    dram_kernel_loader #(
        .DRAM_DATA_BITS(DB), .DRAM_ADDR_BITS(AB), .KER_NUM(KN),
        .KER_WIDTH(KW), .KER_HEIGHT_MAX(KH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dram_base(dram_base),
        .ker_sel(ker_sel), .ker_rows(ker_rows), .busy(busy), .done(done),
        .dram_rd_req(dram_rd_req), .dram_rd_addr(dram_rd_addr),
        .dram_rd_ack(dram_rd_ack), .dram_rd_valid(dram_rd_valid),
        .dram_rd_data(dram_rd_data), .ker_wr_en(ker_wr_en),
        .ker_wr_addr(ker_wr_addr), .ker_wr_data(ker_wr_data)
    );

    int cyc = 0;
    initial forever begin
        #5 clk = 1'b1;
        #5 clk = 1'b0;
        cyc++;
    end

    typedef struct packed {
        logic [KN-1:0] en;
        logic [WW-1:0] addr;
        logic [KW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0, failures = 0;
    int ack_delay = 0, valid_delay = 0;
    int req_cnt = 0, wr_cnt = 0, first_wr_cyc = 0, v_cyc = 0, t0 = 0;
    logic [AB-1:0] exp_raddr = '0, last_req_addr = '0;
    logic [KW-1:0] row6_cap = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DB-1:0] dram_word(input logic [AB-1:0] a);
        logic [DB-1:0] w;
        for (int i = 0; i < DB / 32; i++)
            w[i*32 +: 32] = ({3'b0, a} * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA77) ^ 32'h5BD1E995;
        return w;
    endfunction

    // Row r is stream bits [75r+74:75r], stream = word(base) LSB-first, then word(base+1), ...
    task automatic push_rows(input logic [AB-1:0] base, input logic [SW-1:0] sel, input logic [RW-1:0] rows);
        wr_t           e;
        logic [DB-1:0] w;
        int            cur, pos;
        cur = -1;
        w   = '0;
        for (int r = 0; r < int'(rows); r++) begin
            e.en   = KN'(1) << sel;
            e.addr = WW'(r);
            e.data = '0;
            for (int b = 0; b < KW; b++) begin
                pos = r * KW + b;
                if (pos / DB != cur) begin
                    cur = pos / DB;
                    w   = dram_word(base + AB'(cur));
                end
                e.data[b] = w[pos % DB];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic kick(input logic [AB-1:0] base, input logic [SW-1:0] sel, input logic [RW-1:0] rows);
        @(negedge clk);
        dram_base = base;
        ker_sel   = sel;
        ker_rows  = rows;
        start     = 1'b1;
        exp_raddr = base;
        req_cnt   = 0;
        wr_cnt    = 0;
        row6_cap  = '0;
        t0        = cyc;
        push_rows(base, sel, rows);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < t0 + 2000) @(negedge clk);
        chk("done_seen", done, 1'b1);
    endtask

    // DRAM responder: acks after ack_delay cycles, returns data valid_delay cycles later.
    initial begin
        int phase, wcnt;
        logic [AB-1:0] pend;
        phase = 0;
        wcnt  = 0;
        pend  = '0;
        forever begin
            @(negedge clk);
            dram_rd_ack = 1'b0;
            rv          = 1'b0;
            if (!rst_n) begin
                phase = 0;
                wcnt  = 0;
            end else if (phase == 0) begin
                if (dram_rd_req === 1'b1) begin
                    chk("req_addr", dram_rd_addr, exp_raddr);
                    if (wcnt < ack_delay) begin
                        wcnt++;
                    end else begin
                        dram_rd_ack   = 1'b1;
                        pend          = dram_rd_addr;
                        last_req_addr = dram_rd_addr;
                        exp_raddr     = exp_raddr + AB'(1);
                        req_cnt++;
                        phase = 1;
                        wcnt  = 0;
                    end
                end
            end else begin
                chk("req_dropped_after_ack", dram_rd_req, 1'b0);
                if (wcnt < valid_delay) begin
                    wcnt++;
                end else begin
                    rv    = 1'b1;
                    rdata = dram_word(pend);
                    v_cyc = cyc;
                    phase = 0;
                    wcnt  = 0;
                end
            end
        end
    end

    // Write monitor: every strobe must match the next expected row.
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (ker_wr_en !== '0) begin
            wr_cnt++;
            if (wr_cnt == 1) first_wr_cyc = cyc;
            if (ker_wr_addr === WW'(6)) row6_cap = ker_wr_data;
            chk("wr_without_req", dram_rd_req, 1'b0);
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed en=%b addr=%0d expected none", ker_wr_en, ker_wr_addr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_en", ker_wr_en, e.en);
                chk("wr_addr", ker_wr_addr, e.addr);
                chk("wr_data", ker_wr_data, e.data);
            end
        end
    end

    initial begin
        logic [DB-1:0] w0, w1;
        logic [AB-1:0] b2;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_req", dram_rd_req, 1'b0);
        chk("rst_raddr", dram_rd_addr, '0);
        chk("rst_wr_en", ker_wr_en, '0);
        chk("rst_wr_addr", ker_wr_addr, '0);
        chk("rst_wr_data", ker_wr_data, '0);
        rst_n = 1'b1;

        // Single word, six rows
        kick(29'h100, 2'd0, 11'd6);
        chk("t1_busy", busy, 1'b1);
        chk("t1_req", dram_rd_req, 1'b1);
        wait_done();
        chk("t1_done_cyc", cyc, v_cyc + 7);
        chk("t1_first_wr_cyc", first_wr_cyc, v_cyc + 1);
        chk("t1_busy_at_done", busy, 1'b0);
        chk("t1_reqs", req_cnt, 1);
        chk("t1_writes", wr_cnt, 6);
        chk("t1_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("t1_done_pulse", done, 1'b0);

        // 96 rows across 15 words
        b2 = 29'h0ABCDE0;
        kick(b2, 2'd1, 11'd96);
        wait_done();
        w0 = dram_word(b2);
        w1 = dram_word(b2 + AB'(1));
        chk("t2_reqs", req_cnt, 15);
        chk("t2_last_req", last_req_addr, b2 + AB'(14));
        chk("t2_raddr_end", dram_rd_addr, b2 + AB'(15));
        chk("t2_writes", wr_cnt, 96);
        chk("t2_queue_empty", exp_q.size(), 0);
        chk("t2_row6", row6_cap, {w1[12:0], w0[511:450]});

        // Slow ack and slow data
        ack_delay   = 5;
        valid_delay = 10;
        kick(29'h1F00000, 2'd2, 11'd12);
        wait_done();
        chk("t3_done_cyc", cyc, v_cyc + 7);
        chk("t3_reqs", req_cnt, 2);
        chk("t3_writes", wr_cnt, 12);
        chk("t3_queue_empty", exp_q.size(), 0);
        ack_delay   = 0;
        valid_delay = 0;

        // Zero rows
        kick(29'h55, 2'd0, 11'd0);
        chk("t4_done", done, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_req", dram_rd_req, 1'b0);
        @(negedge clk);
        chk("t4_done_pulse", done, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_reqs", req_cnt, 0);

        // Reset mid-drain, stray data, restart
        kick(29'h200, 2'd0, 11'd6);
        while (wr_cnt < 3 && cyc < t0 + 200) @(negedge clk);
        chk("t5_three_writes", (wr_cnt >= 3), 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_req", dram_rd_req, 1'b0);
        chk("t5_raddr", dram_rd_addr, '0);
        chk("t5_wr_en", ker_wr_en, '0);
        chk("t5_wr_addr", ker_wr_addr, '0);
        chk("t5_wr_data", ker_wr_data, '0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sdata = dram_word(29'h999);
        sv    = 1'b1;
        @(negedge clk);
        sv = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_stray_busy", busy, 1'b0);
        chk("t5_stray_data", ker_wr_data, '0);
        chk("t5_stray_req", dram_rd_req, 1'b0);
        kick(29'h300, 2'd0, 11'd6);
        wait_done();
        chk("t5_reqs", req_cnt, 1);
        chk("t5_writes", wr_cnt, 6);
        chk("t5_queue_empty", exp_q.size(), 0);

        // Stray data in IDLE and REQ, start while busy
        @(negedge clk);
        sdata = dram_word(29'h1234);
        sv    = 1'b1;
        @(negedge clk);
        sv = 1'b0;
        chk("t6_idle_busy", busy, 1'b0);
        chk("t6_idle_data", ker_wr_data, '0);
        ack_delay = 4;
        kick(29'h400, 2'd1, 11'd12);
        sdata = dram_word(29'h4321);
        sv    = 1'b1;
        @(negedge clk);
        sv        = 1'b0;
        dram_base = 29'h7777;
        ker_sel   = 2'd2;
        ker_rows  = 11'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("t6_reqs", req_cnt, 2);
        chk("t6_writes", wr_cnt, 12);
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_raddr_end", dram_rd_addr, 29'h402);
        repeat (5) @(negedge clk);
        chk("t6_idle_after", busy, 1'b0);
        chk("t6_no_extra_reqs", req_cnt, 2);
        ack_delay = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
